// File: rtl/apb_regfile_completer_if.sv
// APB3 bus bundle between a requester and apb_regfile_completer.
interface apb_regfile_completer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_regfile_completer.sv
// APB3 completer over a small register file with fixed wait-state insertion.
// Define APB_REGFILE_ERR_EN to drive PSLVERR on decode errors; otherwise it is tied low.
module apb_regfile_completer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input logic                    PCLK,
    input logic                    PRESETn,
    apb_regfile_completer_if.slave bus
);

    localparam int          IDXW = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

    state_t state, next_state;

    logic [31:0] regs [NUM_REGS];
    logic [31:0] counter;

    logic            cap_write;
    logic [31:0]     cap_wdata;
    logic            cap_err;
    logic [IDXW-1:0] cap_idx;
    logic [31:0]     cap_rdata;
    logic [3:0]      wcnt;

    logic capture, commit, dec;

    logic [31:0]     offset;
    logic [IDXW-1:0] idx;
    logic            addr_err;
    logic            dec_err;
    logic [31:0]     rd_data;

    assign offset   = bus.PADDR - BASE_ADDR;
    assign idx      = offset[IDXW+1:2];
    assign addr_err = (bus.PADDR < BASE_ADDR) || (offset >= SPAN) || (bus.PADDR[1:0] != 2'b00);
    assign dec_err  = addr_err || (bus.PWRITE && (idx < IDXW'(2)));

    // Read data is snapshotted at setup, so the counter reads back its setup-edge value.
    always_comb begin
        rd_data = '0;
        if (!addr_err) begin
            if (idx == IDXW'(0))
                rd_data = ID_VALUE;
            else if (idx == IDXW'(1))
                rd_data = counter;
            else
                rd_data = regs[idx];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        commit     = 1'b0;
        dec        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    capture    = 1'b1;
                    next_state = (WAIT_STATES > 0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (!bus.PSEL) begin
                    next_state = IDLE;
                end else if (bus.PENABLE) begin
                    dec = 1'b1;
                    if (wcnt == 4'd1)
                        next_state = READY;
                end
            end
            READY: begin
                next_state = IDLE;
                commit     = bus.PSEL;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: setup capture, wait countdown, and the completing-edge commit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_rdata <= '0;
            wcnt      <= '0;
            counter   <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (capture) begin
                cap_write <= bus.PWRITE;
                cap_wdata <= bus.PWDATA;
                cap_err   <= dec_err;
                cap_idx   <= idx;
                cap_rdata <= rd_data;
                wcnt      <= 4'(WAIT_STATES);
            end else if (dec) begin
                wcnt <= wcnt - 4'd1;
            end
            if (commit) begin
                if (cap_write && !cap_err)
                    regs[cap_idx] <= cap_wdata;
                counter <= counter + 32'd1;
            end
        end
    end

    assign bus.PREADY = (state == READY);
    assign bus.PRDATA = ((state == READY) && !cap_write && !cap_err) ? cap_rdata : '0;
`ifdef APB_REGFILE_ERR_EN
    assign bus.PSLVERR = (state == READY) && cap_err;
`else
    assign bus.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed bench for apb_regfile_completer: one DUT with 1 wait state, one with 3.
module tb_apb_regfile_completer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] ID   = 32'hA9B0_0001;
`ifdef APB_REGFILE_ERR_EN
    localparam logic [31:0] ERR = 32'd1;
`else
    localparam logic [31:0] ERR = 32'd0;
`endif

    logic PCLK;
    logic PRESETn;

    logic        psel, penable, pwrite, use_slow;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int tests_run = 0;
    int tests_failed = 0;

    apb_regfile_completer_if bus_f ();
    apb_regfile_completer_if bus_s ();

    assign bus_f.PSEL    = psel & ~use_slow;
    assign bus_s.PSEL    = psel & use_slow;
    assign bus_f.PENABLE = penable;
    assign bus_s.PENABLE = penable;
    assign bus_f.PWRITE  = pwrite;
    assign bus_s.PWRITE  = pwrite;
    assign bus_f.PADDR   = paddr;
    assign bus_s.PADDR   = paddr;
    assign bus_f.PWDATA  = pwdata;
    assign bus_s.PWDATA  = pwdata;

    assign prdata  = use_slow ? bus_s.PRDATA  : bus_f.PRDATA;
    assign pready  = use_slow ? bus_s.PREADY  : bus_f.PREADY;
    assign pslverr = use_slow ? bus_s.PSLVERR : bus_f.PSLVERR;

    apb_regfile_completer #(
        .BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_STATES(1), .ID_VALUE(ID)
    ) dut_fast (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_f)
    );

    apb_regfile_completer #(
        .BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_STATES(3), .ID_VALUE(ID)
    ) dut_slow (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus_s)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One full transfer; returns in the PREADY cycle so a following call is back-to-back.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic [31:0] err, output int cycles);
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        cycles = 1;
        @(posedge PCLK); #1;
        penable = 1'b1;
        cycles = 2;
        while (!pready && cycles < 40) begin
            @(posedge PCLK); #1;
            cycles++;
        end
        if (!pready)
            checkOutput("pready_timeout", 32'(pready), 32'd1);
        rdata = prdata;
        err   = 32'(pslverr);
    endtask

    task automatic go_idle();
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [31:0] rd, er;
    int          cyc;

    initial begin
        PRESETn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; use_slow = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge PCLK);
        #1;
        checkOutput("reset_pready", 32'(pready), 32'd0);
        checkOutput("reset_prdata", prdata, 32'd0);
        checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Fast DUT: write/readback back-to-back, counter, ID timing
        applyStimulus(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, rd, er, cyc);
        checkOutput("wr8_cycles", 32'(cyc), 32'd3);
        applyStimulus(1'b0, BASE + 32'h8, 32'h0, rd, er, cyc);
        checkOutput("rd8_data", rd, 32'hDEAD_BEEF);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, rd, er, cyc);
        checkOutput("cnt_after_2", rd, 32'd2);
        applyStimulus(1'b0, BASE, 32'h0, rd, er, cyc);
        checkOutput("id_data", rd, ID);
        checkOutput("id_cycles", 32'(cyc), 32'd3);
        checkOutput("id_err", er, 32'd0);

        // Decode errors
        applyStimulus(1'b1, BASE + 32'h4, 32'h5555_5555, rd, er, cyc);
        checkOutput("wr_ro_err", er, ERR);
        applyStimulus(1'b0, BASE + 32'h40, 32'h0, rd, er, cyc);
        checkOutput("oor_data", rd, 32'd0);
        checkOutput("oor_err", er, ERR);
        applyStimulus(1'b0, BASE + 32'h2, 32'h0, rd, er, cyc);
        checkOutput("misalign_data", rd, 32'd0);
        checkOutput("misalign_err", er, ERR);
        applyStimulus(1'b0, BASE - 32'h4, 32'h0, rd, er, cyc);
        checkOutput("below_data", rd, 32'd0);
        checkOutput("below_err", er, ERR);
        go_idle();
        #0 checkOutput("idle_prdata", prdata, 32'd0);

        // Access phase without setup must be ignored
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = BASE;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            checkOutput("noset_pready", 32'(pready), 32'd0);
        end
        psel = 1'b0; penable = 1'b0;

        applyStimulus(1'b0, BASE + 32'h4, 32'h0, rd, er, cyc);
        checkOutput("cnt_after_8", rd, 32'd8);
        applyStimulus(1'b1, BASE + 32'h3C, 32'hA5A5_0F0F, rd, er, cyc);
        checkOutput("wr_last_err", er, 32'd0);
        applyStimulus(1'b0, BASE + 32'h3C, 32'h0, rd, er, cyc);
        checkOutput("rd_last_data", rd, 32'hA5A5_0F0F);
        applyStimulus(1'b1, BASE + 32'h9, 32'hFFFF_FFFF, rd, er, cyc);
        applyStimulus(1'b0, BASE + 32'h8, 32'h0, rd, er, cyc);
        checkOutput("err_wr_dropped", rd, 32'hDEAD_BEEF);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, rd, er, cyc);
        checkOutput("cnt_after_13", rd, 32'd13);
        go_idle();

        // Slow DUT: abort a write after two access cycles
        use_slow = 1'b1;
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h14; pwdata = 32'h0000_1234;
        for (int i = 0; i < 2; i++) begin
            @(posedge PCLK); #1;
            penable = 1'b1;
            checkOutput("abort_pready", 32'(pready), 32'd0);
        end
        @(posedge PCLK); #1;
        checkOutput("abort_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge PCLK); #1;
            checkOutput("post_abort_pready", 32'(pready), 32'd0);
        end
        applyStimulus(1'b0, BASE + 32'h14, 32'h0, rd, er, cyc);
        checkOutput("abort_reg5", rd, 32'd0);
        checkOutput("slow_cycles", 32'(cyc), 32'd5);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, rd, er, cyc);
        checkOutput("abort_cnt", rd, 32'd1);
        go_idle();

        // Reset during the wait phase of a write to register 3
        @(posedge PCLK); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'hC; pwdata = 32'h0BAD_F00D;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #3;
        PRESETn = 1'b0;
        #1;
        checkOutput("rst_pready", 32'(pready), 32'd0);
        checkOutput("rst_prdata", prdata, 32'd0);
        checkOutput("rst_pslverr", 32'(pslverr), 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        applyStimulus(1'b0, BASE + 32'hC, 32'h0, rd, er, cyc);
        checkOutput("rst_reg3", rd, 32'd0);
        applyStimulus(1'b0, BASE + 32'h4, 32'h0, rd, er, cyc);
        checkOutput("rst_cnt", rd, 32'd1);
        go_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
